pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter IMG_WIDTH, default 1024: pixels per line; SHALL be a multiple of 4, ≥4.
REQ-002 Parameter PIX_W, default 8: pixel width in bits.
REQ-003 clk  input  1  the single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 pixel_in  input  PIX_W  processed pixel from the upstream processing stage.
REQ-006 valid_in  input  1  pixel_in is valid.
REQ-007 ready_out  output  1  packer can accept a pixel; it drives the upstream stage's ready_in.
REQ-008 flush  input  1  single-cycle pulse that emits any partial word and restarts the column count.
REQ-009 word_out  output  4*PIX_W  packed word; the first pixel of the group sits in bits [PIX_W-1:0].
REQ-010 valid_out  output  1  word_out is valid.
REQ-011 ready_in  input  1  downstream accepts word_out.
REQ-012 last_out  output  1  word_out holds the final pixel of a line, or is a flushed word.
REQ-013 busy  output  1  high while a partial word is held or valid_out is high.

Function
REQ-014 A pixel SHALL be accepted only in a cycle where valid_in && ready_out.
REQ-015 A word transfer SHALL complete only in a cycle where valid_out && ready_in.
REQ-016 Accepted pixels SHALL go into lane cnt (0..3); cnt increments per accepted pixel.
REQ-017 On acceptance of the 4th pixel (cnt==3), the next cycle SHALL present {pixel_in, lane2, lane1, lane0} on word_out with valid_out=1, and cnt SHALL return to 0 (latency 1 cycle).
REQ-018 While valid_out=1 and ready_in=0, word_out, valid_out and last_out SHALL hold stable.
REQ-019 ready_out = (cnt!=3) || !valid_out || ready_in (combinational).
REQ-020 A new word SHALL be loadable in the same cycle the previous word transfers, giving sustained throughput of 1 pixel/clk with ready_in held at 1.
REQ-021 A column counter SHALL count accepted pixels 0..IMG_WIDTH-1 and wrap to 0 after the pixel at IMG_WIDTH-1.
REQ-022 last_out SHALL be 1 for exactly the word containing column IMG_WIDTH-1.
REQ-023 flush with cnt>0 SHALL emit the held lanes with the unused upper lanes zero and last_out=1, once the output register is free.
REQ-024 flush SHALL set cnt=0 and column=0.
REQ-025 flush with cnt==0 and no pixel accepted in the same cycle SHALL emit no word and SHALL only clear the column counter.
REQ-026 Flush and an accepted pixel in the same cycle: the pixel SHALL be included in the flushed word.
REQ-027 If the pixel makes 4 lanes, the word SHALL be a normal full word with last_out=1.
REQ-028 flush arriving while the output register is full and stalled SHALL be held pending.
REQ-029 While a flush is pending, ready_out SHALL be 0 until the flushed word is loaded.
REQ-030 No pixel SHALL be dropped or duplicated under any valid_in/ready_in pattern.

Reset
REQ-031 rstn low SHALL immediately force valid_out=0, last_out=0, word_out=0, busy=0, cnt=0, column=0, and flush-pending=0.
REQ-032 While rstn is low, ready_out SHALL be 0.
REQ-033 Reset mid-word SHALL discard partial lanes; after release, the first accepted pixel SHALL be lane 0, column 0.

Structure
REQ-034 A shared package pixel_pkg SHALL hold PIX_W, PACK=4, WORD_W=PACK*PIX_W and the lane-index type.
REQ-035 The output holding register (word, valid, last with valid/ready) SHALL be a sub-module pack_out_reg.
REQ-036 All other logic (lane registers, counters, flush control) SHALL reside in pixel_packer.

Verification
REQ-037 Pixels 0x01,0x02,0x03,0x04 back-to-back with ready_in=1 -> word_out=0x04030201, valid_out=1 one cycle after the 4th accept, last_out=0.
REQ-038 IMG_WIDTH=8 and pixels 0x00..0x07 -> words 0x03020100 (last_out=0) then 0x07060504 (last_out=1); next pixel lands in column 0.
REQ-039 ready_in=0 for 10 cycles after the first word while streaming -> word held stable, ready_out drops after 3 further accepts, no loss or duplication when ready_in returns to 1.
REQ-040 Pixels 0xAA,0xBB then flush -> word_out=0x0000BBAA with last_out=1; flush with cnt==0 -> no valid_out.
REQ-041 Flush in the same cycle as accepted pixel 0xCC after 0xAA,0xBB -> word_out=0x00CCBBAA, last_out=1.
REQ-042 rstn asserted after 2 pixels -> outputs zero at once; after release, 0x11,0x22,0x33,0x44 -> 0x44332211.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared widths and types for the pixel packer slice.
package pixel_pkg;

    localparam int PIX_W  = 8;
    localparam int PACK   = 4;
    localparam int WORD_W = PACK * PIX_W;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel-in / word-out handshake bundle; slave is the packer's view, master the surrounding stages'.
interface pixel_packer_if #(
    parameter int PIX_W = pixel_pkg::PIX_W
);

    logic [PIX_W-1:0]                 pixel_in;
    logic                             valid_in;
    logic                             ready_out;
    logic                             flush;
    logic [pixel_pkg::PACK*PIX_W-1:0] word_out;
    logic                             valid_out;
    logic                             ready_in;
    logic                             last_out;
    logic                             busy;

    modport slave (
        input  pixel_in, valid_in, flush, ready_in,
        output ready_out, word_out, valid_out, last_out, busy
    );

    modport master (
        output pixel_in, valid_in, flush, ready_in,
        input  ready_out, word_out, valid_out, last_out, busy
    );

endinterface

// File: rtl/pack_out_reg.sv
// Output holding register: a word loads whenever the slot is free and holds until the consumer takes it.
module pack_out_reg #(
    parameter int WORD_W = pixel_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              load_last,
    input  logic              ready_in,
    output logic [WORD_W-1:0] word_out,
    output logic              valid_out,
    output logic              last_out,
    output logic              free
);

    assign free = !valid_out || ready_in;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            word_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end else if (load) begin
            word_out  <= load_word;
            valid_out <= 1'b1;
            last_out  <= load_last;
        end else if (ready_in) begin
            valid_out <= 1'b0;
            last_out  <= 1'b0;
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs four pixels per output word, tracks line position for last_out and handles flush of partial words.
module pixel_packer #(
    parameter int IMG_WIDTH = 1024,
    parameter int PIX_W     = pixel_pkg::PIX_W
) (
    input logic           clk,
    input logic           rstn,
    pixel_packer_if.slave bus
);

    import pixel_pkg::PACK;
    import pixel_pkg::lane_t;

    localparam int WORD_W = PACK * PIX_W;
    localparam int COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    logic [PIX_W-1:0]  lanes [PACK-1];
    logic [PIX_W-1:0]  flush_lanes [PACK-1];
    lane_t             cnt;
    logic [COL_W-1:0]  column;
    logic              flush_pend;
    logic              out_free;
    logic              accept;
    logic              full_word;
    logic              col_last;
    logic [2:0]        flush_cnt;
    logic              flush_emit;
    logic              load;
    logic [WORD_W-1:0] load_word;
    logic              load_last;

    assign bus.ready_out = rstn && !flush_pend && ((cnt != 2'd3) || out_free);
    assign accept        = bus.valid_in && bus.ready_out;
    assign full_word     = accept && (cnt == 2'd3);
    assign col_last      = (column == COL_W'(IMG_WIDTH - 1));
    assign bus.busy      = (cnt != 2'd0) || flush_pend || bus.valid_out;

    // Flushed word = held lanes plus this cycle's pixel, upper lanes forced to zero.
    always_comb begin
        flush_cnt = 3'(cnt) + 3'(accept);
        for (int i = 0; i < PACK - 1; i++) begin
            flush_lanes[i] = '0;
            if (i < int'(cnt))
                flush_lanes[i] = lanes[i];
            else if (accept && (cnt == lane_t'(i)))
                flush_lanes[i] = bus.pixel_in;
        end
        flush_emit = bus.flush && !full_word && (flush_cnt != 3'd0);
    end

    always_comb begin
        load      = 1'b0;
        load_word = '0;
        load_last = 1'b0;
        if (full_word) begin
            load      = 1'b1;
            load_word = {bus.pixel_in, lanes[2], lanes[1], lanes[0]};
            load_last = col_last || bus.flush;
        end else if (flush_pend && out_free) begin
            load      = 1'b1;
            load_word = {PIX_W'(0), lanes[2], lanes[1], lanes[0]};
            load_last = 1'b1;
        end else if (flush_emit && out_free) begin
            load      = 1'b1;
            load_word = {PIX_W'(0), flush_lanes[2], flush_lanes[1], flush_lanes[0]};
            load_last = 1'b1;
        end
    end

    // A flush that cannot load immediately parks its masked lanes and blocks input until they go out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            column     <= '0;
            flush_pend <= 1'b0;
            for (int i = 0; i < PACK - 1; i++)
                lanes[i] <= '0;
        end else begin
            if (accept && !bus.flush && !full_word) begin
                for (int i = 0; i < PACK - 1; i++)
                    if (cnt == lane_t'(i))
                        lanes[i] <= bus.pixel_in;
            end
            if (bus.flush) begin
                cnt    <= '0;
                column <= '0;
                if (flush_emit && !out_free) begin
                    flush_pend <= 1'b1;
                    for (int i = 0; i < PACK - 1; i++)
                        lanes[i] <= flush_lanes[i];
                end
            end else if (accept) begin
                cnt    <= cnt + 2'd1;
                column <= col_last ? '0 : column + COL_W'(1);
            end
            if (flush_pend && out_free)
                flush_pend <= 1'b0;
        end
    end

    pack_out_reg #(
        .WORD_W (WORD_W)
    ) u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .load_word (load_word),
        .load_last (load_last),
        .ready_in  (bus.ready_in),
        .word_out  (bus.word_out),
        .valid_out (bus.valid_out),
        .last_out  (bus.last_out),
        .free      (out_free)
    );

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer with an 8-pixel line: cycle table plus stall-stream and reset sequences.
module tb_pixel_packer;

    localparam int IMG_WIDTH = 8;
    localparam int PIX_W     = 8;

    typedef struct {
        bit        v;
        bit [7:0]  p;
        bit        f;
        bit        r;
        bit        e_ro;
        bit        e_vo;
        bit [31:0] e_w;
        bit        e_l;
    } vec_t;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;
    vec_t vecs[$];

    pixel_packer_if #(.PIX_W(PIX_W)) bus ();

    pixel_packer #(
        .IMG_WIDTH (IMG_WIDTH),
        .PIX_W     (PIX_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input bit v, input bit [7:0] p, input bit f, input bit r,
                       input bit e_ro, input bit e_vo, input bit [31:0] e_w, input bit e_l);
        vec_t t;
        t.v = v; t.p = p; t.f = f; t.r = r;
        t.e_ro = e_ro; t.e_vo = e_vo; t.e_w = e_w; t.e_l = e_l;
        vecs.push_back(t);
    endtask

    task automatic apply_stimulus(input bit v, input bit [7:0] p, input bit f, input bit r);
        bus.valid_in = v;
        bus.pixel_in = p;
        bus.flush    = f;
        bus.ready_in = r;
    endtask

    // Rows give per-cycle inputs and the outputs expected just before that cycle's rising edge.
    task automatic fill_table();
        // 0x00..0x07: one full line, then a new line starts at column 0
        for (int i = 0; i < 8; i++)
            add(1, 8'(i), 0, 1, 1, (i == 4), 32'h03020100, 0);
        add(0, 0, 0, 1, 1, 1, 32'h07060504, 1);
        for (int i = 1; i <= 4; i++) add(1, 8'(i), 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h04030201, 0);
        for (int i = 5; i <= 8; i++) add(1, 8'(i), 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h08070605, 1);
        // partial flush, then a flush with nothing held
        add(1, 8'hAA, 0, 1, 1, 0, 0, 0);
        add(1, 8'hBB, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h0000BBAA, 1);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        // flush together with an accepted pixel
        add(1, 8'hAA, 0, 1, 1, 0, 0, 0);
        add(1, 8'hBB, 0, 1, 1, 0, 0, 0);
        add(1, 8'hCC, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h00CCBBAA, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        // flush on the fourth pixel gives a full word marked last
        add(1, 8'h11, 0, 1, 1, 0, 0, 0);
        add(1, 8'h22, 0, 1, 1, 0, 0, 0);
        add(1, 8'h33, 0, 1, 1, 0, 0, 0);
        add(1, 8'h44, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h44332211, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        // flush while the output is stalled: held pending, input blocked
        for (int i = 1; i <= 4; i++) add(1, 8'(i), 0, 0, 1, 0, 0, 0);
        add(1, 8'h05, 0, 0, 1, 1, 32'h04030201, 0);
        add(1, 8'h06, 1, 0, 1, 1, 32'h04030201, 0);
        add(1, 8'h07, 0, 0, 0, 1, 32'h04030201, 0);
        add(1, 8'h07, 0, 1, 0, 1, 32'h04030201, 0);
        add(1, 8'h07, 0, 1, 1, 1, 32'h00000605, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1, 32'h00000007, 1);
        add(0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic run_table();
        foreach (vecs[k]) begin
            @(negedge clk);
            apply_stimulus(vecs[k].v, vecs[k].p, vecs[k].f, vecs[k].r);
            #1;
            check_output($sformatf("row%0d_ready_out", k), 32'(bus.ready_out), 32'(vecs[k].e_ro));
            check_output($sformatf("row%0d_valid_out", k), 32'(bus.valid_out), 32'(vecs[k].e_vo));
            if (vecs[k].e_vo) begin
                check_output($sformatf("row%0d_word_out", k), bus.word_out, vecs[k].e_w);
                check_output($sformatf("row%0d_last_out", k), 32'(bus.last_out), 32'(vecs[k].e_l));
            end
        end
        @(negedge clk);
        apply_stimulus(0, 0, 0, 1);
    endtask

    // 16 pixels streamed; downstream stalls for 10 cycles as soon as the first word shows.
    task automatic run_stall_stream();
        logic [31:0] exp_words [4];
        int sent = 0;
        int recv = 0;
        int stall_left = 0;
        int stall_accepts = 0;
        bit stall_started = 0;
        bit ro;
        bit vo;
        for (int k = 0; k < 4; k++)
            for (int b = 0; b < 4; b++)
                exp_words[k][8*b +: 8] = 8'(8'h20 + 4*k + b);
        for (int cyc = 0; cyc < 200 && recv < 4; cyc++) begin
            @(negedge clk);
            if (!stall_started && bus.valid_out) begin
                stall_started = 1;
                stall_left    = 10;
            end
            apply_stimulus(sent < 16, 8'(8'h20 + sent), 0, stall_left == 0);
            #1;
            ro = bus.ready_out;
            vo = bus.valid_out;
            if (stall_left > 0) begin
                check_output("stall_valid_held", 32'(vo), 32'd1);
                check_output("stall_word_held", bus.word_out, exp_words[0]);
                if (bus.valid_in && ro) stall_accepts++;
                if (stall_left == 1) check_output("stall_ready_low", 32'(ro), 32'd0);
                stall_left--;
            end
            if (vo && bus.ready_in) begin
                check_output($sformatf("stream_word%0d", recv), bus.word_out, exp_words[recv]);
                check_output($sformatf("stream_last%0d", recv), 32'(bus.last_out), 32'(recv % 2 == 1));
                recv++;
            end
            if (bus.valid_in && ro) sent++;
        end
        @(negedge clk);
        apply_stimulus(0, 0, 0, 1);
        check_output("stall_accepts", 32'(stall_accepts), 32'd3);
        check_output("stream_words_received", 32'(recv), 32'd4);
        check_output("stream_pixels_sent", 32'(sent), 32'd16);
    endtask

    task automatic run_reset_midword();
        int waited = 0;
        @(negedge clk);
        apply_stimulus(1, 8'h55, 0, 1);
        @(negedge clk);
        apply_stimulus(1, 8'h66, 0, 1);
        @(negedge clk);
        apply_stimulus(0, 0, 0, 1);
        #1;
        check_output("pre_reset_busy", 32'(bus.busy), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        check_output("mid_reset_valid_out", 32'(bus.valid_out), 32'd0);
        check_output("mid_reset_word_out", bus.word_out, 32'd0);
        check_output("mid_reset_last_out", 32'(bus.last_out), 32'd0);
        check_output("mid_reset_busy", 32'(bus.busy), 32'd0);
        check_output("mid_reset_ready_out", 32'(bus.ready_out), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            apply_stimulus(1, 8'(8'h11 * i), 0, 1);
        end
        @(negedge clk);
        apply_stimulus(0, 0, 0, 1);
        #1;
        while (!bus.valid_out && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check_output("post_reset_valid_out", 32'(bus.valid_out), 32'd1);
        check_output("post_reset_word_out", bus.word_out, 32'h44332211);
        check_output("post_reset_last_out", 32'(bus.last_out), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        apply_stimulus(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_output("reset_valid_out", 32'(bus.valid_out), 32'd0);
        check_output("reset_word_out", bus.word_out, 32'd0);
        check_output("reset_last_out", 32'(bus.last_out), 32'd0);
        check_output("reset_busy", 32'(bus.busy), 32'd0);
        check_output("reset_ready_out", 32'(bus.ready_out), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        fill_table();
        run_table();
        run_stall_stream();
        run_reset_midword();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
